// File: rtl/gray_sync_decoder.sv
// rtl/gray_sync_decoder.sv - two-flop Gray synchroniser with binary conversion, step delta and step-error counting
module gray_sync_decoder #(
  parameter int W    = 8,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    gray_in,
  input  logic            err_clr,
  output logic [W-1:0]    bin_out,
  output logic            bin_valid,
  output logic            bin_chg,
  output logic [W-1:0]    delta,
  output logic            step_err,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     warm_cnt, warm_cnt_nxt;
  logic [W-1:0]   sync1, sync2;
  logic [W-1:0]   prev_gray, prev_gray_nxt;
  logic [W-1:0]   bin_out_nxt, delta_nxt;
  logic           bin_valid_nxt, bin_chg_nxt, step_err_nxt;
  logic           err_inc;
  logic [W-1:0]   bin_sync;
  logic [W-1:0]   gray_diff;
  logic           any_change, multi_change;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Two-flop synchroniser; runs every cycle, warmup included
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray_in;
      sync2 <= sync1;
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits flipped
  always_comb begin
    bin_sync     = g2b(sync2);
    gray_diff    = sync2 ^ prev_gray;
    any_change   = (gray_diff != '0);
    multi_change = ((gray_diff & (gray_diff - 1'b1)) != '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WARMUP;
      warm_cnt  <= '0;
      prev_gray <= '0;
      bin_out   <= '0;
      delta     <= '0;
      bin_valid <= 1'b0;
      bin_chg   <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      warm_cnt  <= warm_cnt_nxt;
      prev_gray <= prev_gray_nxt;
      bin_out   <= bin_out_nxt;
      delta     <= delta_nxt;
      bin_valid <= bin_valid_nxt;
      bin_chg   <= bin_chg_nxt;
      step_err  <= step_err_nxt;
    end
  end

  // Next-state logic: wait for the synchroniser to fill, then track changes in sync2
  always_comb begin
    state_nxt     = state;
    warm_cnt_nxt  = warm_cnt;
    prev_gray_nxt = prev_gray;
    bin_out_nxt   = bin_out;
    delta_nxt     = delta;
    bin_valid_nxt = bin_valid;
    bin_chg_nxt   = 1'b0;
    step_err_nxt  = 1'b0;
    err_inc       = 1'b0;
    case (state)
      WARMUP: begin
        warm_cnt_nxt = warm_cnt + 2'd1;
        if (warm_cnt == 2'd2) begin
          // First meaningful sample: adopt it without reporting a step
          prev_gray_nxt = sync2;
          bin_out_nxt   = bin_sync;
          delta_nxt     = '0;
          bin_valid_nxt = 1'b1;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        if (any_change) begin
          prev_gray_nxt = sync2;
          bin_out_nxt   = bin_sync;
          delta_nxt     = bin_sync - bin_out;
          bin_chg_nxt   = 1'b1;
          if (multi_change) begin
            step_err_nxt = 1'b1;
            err_inc      = 1'b1;
          end
        end
      end
      default: state_nxt = WARMUP;
    endcase
  end

  // Saturating error counter; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (err_inc && (err_count != {ERRW{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb/tb_gray_sync_decoder.sv - self-checking bench for gray_sync_decoder against a behavioural model
module tb_gray_sync_decoder;

  localparam int W    = 8;
  localparam int ERRW = 8;

  logic            clk;
  logic            rst;
  logic [W-1:0]    gray_in;
  logic            err_clr;
  logic [W-1:0]    bin_out;
  logic            bin_valid;
  logic            bin_chg;
  logic [W-1:0]    delta;
  logic            step_err;
  logic [ERRW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // model state
  logic [W-1:0] hist[$];
  int           m_since_rst;
  logic         m_valid;
  logic [W-1:0] m_prev, m_bin, m_delta;
  logic         m_chg, m_err;
  int           m_cnt;
  int           n_chg, n_err;

  gray_sync_decoder #(.W(W), .ERRW(ERRW)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .err_clr   (err_clr),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .bin_chg   (bin_chg),
    .delta     (delta),
    .step_err  (step_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] to_gray(input int v);
    logic [W-1:0] b;
    b = v[W-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the sampled inputs
  task automatic model_step();
    logic [W-1:0] g;
    int           hd;
    if (rst) begin
      hist = '{0, 0};
      m_since_rst = 0;
      m_valid = 0; m_prev = 0; m_bin = 0; m_delta = 0;
      m_chg = 0; m_err = 0; m_cnt = 0;
    end else begin
      g = hist[1];                 // value two samples old
      hist.pop_back();
      hist.push_front(gray_in);
      m_chg = 0; m_err = 0;
      if (!m_valid) begin
        m_since_rst++;
        if (m_since_rst == 3) begin
          m_valid = 1; m_prev = g; m_bin = to_bin(g); m_delta = 0;
        end
      end else begin
        hd = $countones(g ^ m_prev);
        if (hd >= 1) begin
          m_delta = to_bin(g) - m_bin;
          m_bin   = to_bin(g);
          m_prev  = g;
          m_chg   = 1;
        end
        if (hd >= 2) m_err = 1;
      end
      if (err_clr) m_cnt = 0;
      else if (m_err && m_cnt < (1 << ERRW) - 1) m_cnt++;
    end
  endtask

  task automatic compare_all();
    chk("bin_out",   bin_out,   m_bin);
    chk("bin_valid", bin_valid, m_valid);
    chk("bin_chg",   bin_chg,   m_chg);
    chk("delta",     delta,     m_delta);
    chk("step_err",  step_err,  m_err);
    chk("err_count", err_count, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    n_chg += int'(bin_chg);
    n_err += int'(step_err);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    hist = '{0, 0};
    m_since_rst = 0; m_valid = 0; m_prev = 0; m_bin = 0; m_delta = 0;
    m_chg = 0; m_err = 0; m_cnt = 0; n_chg = 0; n_err = 0;
    rst = 1'b1; gray_in = '0; err_clr = 1'b0;

    // reset with gray 0: warmup takes three edges
    ticks(2);
    chk("rst_bin", bin_out, 0);
    chk("rst_valid", bin_valid, 0);
    chk("rst_err", err_count, 0);
    rst = 1'b0;
    tick(); chk("warm1_valid", bin_valid, 0);
    tick(); chk("warm2_valid", bin_valid, 0);
    tick(); chk("warm3_valid", bin_valid, 1);
    chk("warm3_bin", bin_out, 0);
    chk("warm3_chg", bin_chg, 0);
    chk("warm3_err", step_err, 0);

    // reset with 0xC0 held
    rst = 1'b1; gray_in = 8'hC0; tick();
    rst = 1'b0; ticks(3);
    chk("c0_bin", bin_out, 8'h80);
    chk("c0_valid", bin_valid, 1);
    chk("c0_delta", delta, 0);
    chk("c0_err", step_err, 0);

    // full up-count with wrap
    rst = 1'b1; gray_in = '0; tick();
    rst = 1'b0; ticks(3);
    n_chg = 0; n_err = 0;
    for (int v = 1; v <= 256; v++) begin
      gray_in = to_gray(v);
      ticks(3);
      chk("up_bin", bin_out, v & 255);
      chk("up_chg", bin_chg, 1);
      chk("up_delta", delta, 1);
      tick();
    end
    ticks(4);
    chk("up_nchg", n_chg, 256);
    chk("up_nerr", n_err, 0);
    chk("up_errcnt", err_count, 0);

    // illegal jump then legal down-step
    gray_in = 8'h03; ticks(3);
    chk("jmp_bin", bin_out, 2);
    chk("jmp_delta", delta, 2);
    chk("jmp_chg", bin_chg, 1);
    chk("jmp_err", step_err, 1);
    chk("jmp_cnt", err_count, 1);
    tick();
    chk("jmp_err_pulse", step_err, 0);
    chk("jmp_chg_pulse", bin_chg, 0);
    gray_in = 8'h01; ticks(3);
    chk("dn_bin", bin_out, 1);
    chk("dn_delta", delta, 8'hFF);
    chk("dn_err", step_err, 0);
    chk("dn_cnt", err_count, 1);

    // saturation
    gray_in = 8'h00; ticks(4);
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 8'h03 : 8'h00;
      ticks(4);
    end
    chk("sat_cnt", err_count, 255);
    gray_in = 8'h03; ticks(4);
    chk("sat_hold", err_count, 255);

    // clear coinciding with an illegal jump
    gray_in = 8'h00; ticks(2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_err", step_err, 1);
    chk("clr_cnt", err_count, 0);
    ticks(2);

    // randomised mix of legal steps, jumps and clears
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) gray_in = W'($urandom);
      else gray_in = gray_in ^ (W'(1) << $urandom_range(0, W - 1));
      err_clr = ($urandom_range(0, 9) == 0);
      tick();
      err_clr = 1'b0;
      ticks($urandom_range(0, 3));
    end

    // mid-run reset while bin_out = 0x55
    gray_in = to_gray(8'h55); ticks(4);
    chk("mid_bin", bin_out, 8'h55);
    rst = 1'b1; tick();
    chk("mid_rst_bin", bin_out, 0);
    chk("mid_rst_valid", bin_valid, 0);
    chk("mid_rst_delta", delta, 0);
    chk("mid_rst_cnt", err_count, 0);
    rst = 1'b0; ticks(3);
    chk("mid_valid", bin_valid, 1);
    chk("mid_bin2", bin_out, 8'h55);
    chk("mid_err", step_err, 0);
    chk("mid_chg", bin_chg, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
